seven_segment_scan_driver: RTL and testbench

Time-multiplexed driver for the six-digit clock display, sitting between the time-keeping counters and the board's shared segment bus and digit anodes. It latches six BCD digit values once per frame and scans the digits one at a time. For each digit it drives the active-low segment pattern and enables that digit's anode. A blanking guard interval between digits suppresses ghosting, and per-digit blink and decimal-point masks are supported.

---
 rtl/seven_segment_scan_driver.sv | 173 +++++++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver.sv
// rtl/seven_segment_scan_driver.sv - six-digit multiplexed seven-segment scanner with guard, blink and dp masks
module seven_segment_scan_driver #(
  parameter int DIGIT_TICKS  = 50000,
  parameter int GUARD_TICKS  = 500,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [35:0] digit_values,
  input  logic [5:0]  blink_mask,
  input  logic [5:0]  dp_mask,
  output logic [6:0]  segments,
  output logic        dp_n,
  output logic [5:0]  anodes,
  output logic        frame_start
);

  localparam int MAX_TICKS = (DIGIT_TICKS > GUARD_TICKS) ? DIGIT_TICKS : GUARD_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TW-1:0] GUARD_LAST = TW'(GUARD_TICKS - 1);
  localparam logic [TW-1:0] DIGIT_LAST = TW'(DIGIT_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [2:0]       idx, idx_d;
  logic [TW-1:0]    tick, tick_d;
  logic [FW-1:0]    frame, frame_d;
  logic             blink_phase, blink_phase_d;
  logic [5:0][5:0]  sh_digits, sh_digits_d;
  logic [5:0]       sh_blink, sh_blink_d;
  logic [5:0]       sh_dp, sh_dp_d;
  logic [6:0]       segments_d;
  logic             dp_n_d;
  logic [5:0]       anodes_d;
  logic             frame_start_d;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 is blank.
  function automatic logic [6:0] decode(input logic [5:0] v);
    logic [6:0] s;
    case (v)
      6'd0:    s = 7'b1000000;
      6'd1:    s = 7'b1111001;
      6'd2:    s = 7'b0100100;
      6'd3:    s = 7'b0110000;
      6'd4:    s = 7'b0011001;
      6'd5:    s = 7'b0010010;
      6'd6:    s = 7'b0000010;
      6'd7:    s = 7'b1111000;
      6'd8:    s = 7'b0000000;
      6'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Next-state, counters, shadow capture and the next registered output values.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    tick_d        = tick;
    frame_d       = frame;
    blink_phase_d = blink_phase;
    sh_digits_d   = sh_digits;
    sh_blink_d    = sh_blink;
    sh_dp_d       = sh_dp;
    frame_start_d = 1'b0;
    anodes_d      = 6'b111111;
    segments_d    = 7'b1111111;
    dp_n_d        = 1'b1;

    if (!enable) begin
      state_d       = IDLE;
      idx_d         = 3'd0;
      tick_d        = '0;
      frame_d       = '0;
      blink_phase_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_d       = GUARD;
          idx_d         = 3'd0;
          tick_d        = '0;
          frame_start_d = 1'b1;
        end
        GUARD: begin
          if (tick == GUARD_LAST) begin
            state_d = ON;
            tick_d  = '0;
          end else begin
            tick_d = tick + 1'b1;
          end
        end
        ON: begin
          if (tick == DIGIT_LAST) begin
            state_d = GUARD;
            tick_d  = '0;
            if (idx == 3'd5) begin
              idx_d         = 3'd0;
              frame_start_d = 1'b1;
              if (frame == FRAME_LAST) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase;
              end else begin
                frame_d = frame + 1'b1;
              end
            end else begin
              idx_d = idx + 3'd1;
            end
          end else begin
            tick_d = tick + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Inputs are latched on the same edge that raises frame_start, so a frame is always coherent.
    if (frame_start_d) begin
      sh_digits_d = digit_values;
      sh_blink_d  = blink_mask;
      sh_dp_d     = dp_mask;
    end

    if (state_d == ON) begin
      anodes_d = ~(6'b000001 << idx_d);
      if (!(blink_phase_d && sh_blink_d[idx_d])) begin
        segments_d = decode(sh_digits_d[idx_d]);
        dp_n_d     = ~sh_dp_d[idx_d];
      end
    end
  end

  // State, counters, shadows and outputs all register together so segments and anodes switch on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= 3'd0;
      tick        <= '0;
      frame       <= '0;
      blink_phase <= 1'b0;
      sh_digits   <= '0;
      sh_blink    <= '0;
      sh_dp       <= '0;
      anodes      <= 6'b111111;
      segments    <= 7'b1111111;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      tick        <= tick_d;
      frame       <= frame_d;
      blink_phase <= blink_phase_d;
      sh_digits   <= sh_digits_d;
      sh_blink    <= sh_blink_d;
      sh_dp       <= sh_dp_d;
      anodes      <= anodes_d;
      segments    <= segments_d;
      dp_n        <= dp_n_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb/tb_seven_segment_scan_driver.sv - scoreboard bench for seven_segment_scan_driver
module tb_seven_segment_scan_driver;

  localparam int D     = 4;
  localparam int G     = 1;
  localparam int BF    = 2;
  localparam int SLOT  = G + D;
  localparam int FRAME = 6 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [35:0] digit_values;
  logic [5:0]  blink_mask;
  logic [5:0]  dp_mask;
  logic [6:0]  segments;
  logic        dp_n;
  logic [5:0]  anodes;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  logic [14:0]     exp_q[$];
  bit              running = 1'b0;
  int              t = 0;
  logic [5:0][5:0] m_dig;
  logic [5:0]      m_blink;
  logic [5:0]      m_dp;

  seven_segment_scan_driver #(
    .DIGIT_TICKS(D),
    .GUARD_TICKS(G),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .digit_values(digit_values),
    .blink_mask(blink_mask),
    .dp_mask(dp_mask),
    .segments(segments),
    .dp_n(dp_n),
    .anodes(anodes),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [5:0] v);
    case (v)
      6'd0: return 7'b1000000;
      6'd1: return 7'b1111001;
      6'd2: return 7'b0100100;
      6'd3: return 7'b0110000;
      6'd4: return 7'b0011001;
      6'd5: return 7'b0010010;
      6'd6: return 7'b0000010;
      6'd7: return 7'b1111000;
      6'd8: return 7'b0000000;
      6'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected {frame_start, anodes, segments, dp_n} for the cycle after the coming edge.
  task automatic predict();
    logic [5:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic       fs;
    int r, f, slot, sub;
    an = 6'b111111; seg = 7'b1111111; dpn = 1'b1; fs = 1'b0;
    if (!rst_n || !enable) begin
      running = 1'b0;
    end else begin
      if (!running) begin
        running = 1'b1;
        t = 0;
      end else begin
        t++;
      end
      r    = t % FRAME;
      f    = t / FRAME;
      slot = r / SLOT;
      sub  = r % SLOT;
      if (r == 0) begin
        m_dig   = digit_values;
        m_blink = blink_mask;
        m_dp    = dp_mask;
        fs      = 1'b1;
      end
      if (sub >= G) begin
        an[slot] = 1'b0;
        if (!(((f / BF) % 2) == 1 && m_blink[slot])) begin
          seg = ref_seg(m_dig[slot]);
          dpn = ~m_dp[slot];
        end
      end
    end
    exp_q.push_back({fs, an, seg, dpn});
  endtask

  task automatic step(input string tag);
    logic [14:0] e;
    logic [14:0] obs;
    predict();
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {frame_start, anodes, segments, dp_n};
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s t=%0d observed fs/an/seg/dp=%b expected=%b", tag, t, obs, e);
    end
    checks++;
    assert ($countones(~anodes) <= 1) else begin
      failures++;
      $error("FAIL %s_one_anode t=%0d observed anodes=%b expected at most one low", tag, t, anodes);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] e);
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  initial begin
    rst_n        = 1'b1;
    enable       = 1'b0;
    digit_values = {6'd9, 6'd5, 6'd3, 6'd2, 6'd0, 6'd1};
    blink_mask   = 6'b000000;
    dp_mask      = 6'b000000;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", {anodes, segments, dp_n, frame_start, 1'b0}, {6'b111111, 7'b1111111, 1'b1, 1'b0, 1'b0});
    repeat (3) step("reset");
    rst_n = 1'b1;
    repeat (5) step("idle");

    enable = 1'b1;
    step("start");
    chk("fs_first", {15'd0, frame_start}, 16'd1);
    step("d0_first");
    chk("d0_anode_seg", {3'b000, anodes, segments}, {3'b000, 6'b111110, 7'b1111001});
    while (t < 47) step("scan");

    digit_values[5:0] = 6'd7;
    while (t < 91) step("midframe");
    chk("d0_now7", {9'd0, segments}, {9'd0, 7'b1111000});

    blink_mask         = 6'b000011;
    dp_mask            = 6'b000100;
    digit_values[23:18] = 6'd12;
    while (t < 322) step("blink");

    enable = 1'b0;
    step("off");
    chk("off_dark", {2'b00, anodes, segments, dp_n}, {2'b00, 6'b111111, 7'b1111111, 1'b1});
    repeat (2) step("off");

    enable = 1'b1;
    step("restart");
    chk("fs_restart", {15'd0, frame_start}, 16'd1);
    while (t < 35) step("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
